// File: rtl/int_ctrl_if.sv
// int_ctrl_if
//   Wishbone-style register bus between the system intercon and the
//   interrupt controller. The master drives the strobe, write enable,
//   address and write data. The slave returns registered read data and a
//   registered acknowledge.
//
//   Signals:
//     STB    master -> slave  strobe, held high until ACK
//     WE     master -> slave  write enable, valid with STB
//     ADDR   master -> slave  byte address (int_ctrl decodes ADDR[3:2])
//     DAT_I  master -> slave  write data
//     DAT_O  slave -> master  registered read data
//     ACK    slave -> master  registered acknowledge
interface int_ctrl_if;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    modport master (
        output STB,
        output WE,
        output ADDR,
        output DAT_I,
        input  DAT_O,
        input  ACK
    );

    modport slave (
        input  STB,
        input  WE,
        input  ADDR,
        input  DAT_I,
        output DAT_O,
        output ACK
    );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl
//   Priority interrupt controller in front of the CPU's INT/Cause_in inputs.
//   It detects rising edges on up to N_SRC device interrupt lines and latches
//   them as pending bits. Pending, mask, status and software-trigger
//   registers are accessible over a Wishbone slave port. The block drives a
//   level interrupt and the cause code of the highest-priority (lowest index)
//   unmasked pending source.
//
//   Register map (ADDR[3:2]):
//     0 PENDING  read pending / write-1-to-clear
//     1 MASK     read/write, 1 = source enabled, resets to 0
//     2 STATUS   read-only {INT, 26'b0, cause[4:0]}
//     3 SOFT     write ORs data into pending, reads 0
//
//   Ports:
//     clk     system clock (clk100 domain)
//     rst     asynchronous active-high reset
//     irq_in  device interrupt lines, rising edge significant
//     bus     Wishbone slave (int_ctrl_if.slave)
//     INT     level interrupt to the CPU
//     CAUSE   cause code of the highest-priority unmasked pending source
//
//   Configuration macro:
//     INT_CTRL_SYNC_EN  when defined, irq_in passes through a 2-flop
//                       synchronizer before edge detection. Leave it
//                       undefined only when every source is synchronous
//                       to clk.
module int_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    int_ctrl_if.slave        bus,
    output logic             INT,
    output logic [31:0]      CAUSE
);

    localparam int PAD = 32 - N_SRC;

    logic [N_SRC-1:0] sample;
    logic [N_SRC-1:0] irq_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] clr_bits;
    logic [N_SRC-1:0] soft_bits;
    logic [4:0]       cause_idx;
    logic             accept;
    logic             wr_en;
    logic [1:0]       reg_sel;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign unused_bits = ^{bus.ADDR[31:4], bus.ADDR[1:0], bus.DAT_I[31:N_SRC]};

`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    // Two-flop synchronizer for sources coming from other clock domains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign sample = sync2;
`else
    assign sample = irq_in;
`endif

    assign rise = sample & ~irq_d;

    // A strobe is accepted only on its first edge (ACK still low), so a
    // long-held strobe performs exactly one write.
    assign accept  = bus.STB & ~bus.ACK;
    assign wr_en   = accept & bus.WE;
    assign reg_sel = bus.ADDR[3:2];

    assign clr_bits  = (wr_en && reg_sel == 2'd0) ? bus.DAT_I[N_SRC-1:0] : '0;
    assign soft_bits = (wr_en && reg_sel == 2'd3) ? bus.DAT_I[N_SRC-1:0] : '0;

    assign active = pending & mask;

    // Lowest index wins: scan downward so the last hit is the lowest bit.
    always_comb begin
        cause_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                cause_idx = 5'(i);
            end
        end
    end

    assign INT   = |active;
    assign CAUSE = {27'b0, cause_idx};

    // Set terms are ORed after the clear so a coincident edge survives a W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irq_d   <= sample;
            pending <= (pending & ~clr_bits) | rise | soft_bits;
            if (wr_en && reg_sel == 2'd1) begin
                mask <= bus.DAT_I[N_SRC-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    rd_data = {{PAD{1'b0}}, pending};
            2'd1:    rd_data = {{PAD{1'b0}}, mask};
            2'd2:    rd_data = {INT, 26'b0, cause_idx};
            default: rd_data = '0;
        endcase
    end

    // ACK simply follows STB one cycle late; read data is refreshed on
    // every strobed edge and held between accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ACK   <= 1'b0;
            bus.DAT_O <= '0;
        end else begin
            bus.ACK <= bus.STB;
            if (bus.STB) begin
                bus.DAT_O <= rd_data;
            end
        end
    end

endmodule
